// File: rtl/reg_file_sb_if.sv
// Bus bundle for reg_file_sb: read ports, reservation handshake, write ports
// and debug observation.
interface reg_file_sb_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRD   = 2,
  parameter int NWR   = 2
);
  localparam int AW = $clog2(NREGS);

  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;
  logic                rsv_valid;
  logic [AW-1:0]       rsv_addr;
  logic                rsv_ready;
  logic [NWR-1:0]      wr_en;
  logic [NWR*AW-1:0]   wr_addr;
  logic [NWR*XLEN-1:0] wr_data;
  logic [NREGS-1:0]    busy_vec;
  logic [XLEN-1:0]     a0;

  modport master (
    output rd_addr, rsv_valid, rsv_addr, wr_en, wr_addr, wr_data,
    input  rd_data, rd_busy, rsv_ready, busy_vec, a0
  );

  modport slave (
    input  rd_addr, rsv_valid, rsv_addr, wr_en, wr_addr, wr_data,
    output rd_data, rd_busy, rsv_ready, busy_vec, a0
  );
endinterface

// File: rtl/reg_file_sb.sv
// Multi-port register file with a per-register busy scoreboard, optional
// same-cycle write-to-read forwarding, and a hard-wired zero register.
module reg_file_sb #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int NRD    = 2,
  parameter int NWR    = 2,
  parameter int BYPASS = 1
) (
  input  logic         clk,
  input  logic         rst,
  reg_file_sb_if.slave bus
);
  localparam int            AW      = $clog2(NREGS);
  localparam logic [AW-1:0] A0_ADDR = AW'(10);

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] busy;

  logic [AW-1:0]    rd_a      [NRD];
  logic [AW-1:0]    wr_a      [NWR];
  logic [XLEN-1:0]  wr_d      [NWR];
  logic [NWR-1:0]   wr_commit;
  logic [XLEN-1:0]  rd_val    [NRD];
  logic [NRD-1:0]   rd_fwd;
  logic [XLEN-1:0]  a0_val;
  logic             fwd_en;
  logic             rsv_ready;
  logic             rsv_take;

  for (genvar gj = 0; gj < NWR; gj++) begin : g_wr
    assign wr_a[gj]      = bus.wr_addr[gj*AW +: AW];
    assign wr_d[gj]      = bus.wr_data[gj*XLEN +: XLEN];
    assign wr_commit[gj] = bus.wr_en[gj] && (wr_a[gj] != '0);
  end

  // Forwarding is suppressed while reset is held so every read returns zero.
  assign fwd_en = (BYPASS != 0) && rst;

  // Only the registered busy state is consulted, so a clear landing this
  // cycle cannot open the reservation early.
  assign rsv_ready = (bus.rsv_addr == '0) || !busy[bus.rsv_addr];
  assign rsv_take  = bus.rsv_valid && rsv_ready && (bus.rsv_addr != '0);

  // NOTE: every variable gets a value before any conditional override, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    for (int i = 0; i < NRD; i++) begin
      rd_val[i] = regs[rd_a[i]];
      rd_fwd[i] = 1'b0;
      for (int j = 0; j < NWR; j++) begin
        if (fwd_en && wr_commit[j] && (wr_a[j] == rd_a[i])) begin
          rd_val[i] = wr_d[j];
          rd_fwd[i] = 1'b1;
        end
      end
    end
    a0_val = regs[A0_ADDR];
    for (int j = 0; j < NWR; j++) begin
      if (fwd_en && wr_commit[j] && (wr_a[j] == A0_ADDR)) a0_val = wr_d[j];
    end
  end

  for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
    assign rd_a[gi]                        = bus.rd_addr[gi*AW +: AW];
    assign bus.rd_data[gi*XLEN +: XLEN]    = rd_val[gi];
    assign bus.rd_busy[gi]                 = busy[rd_a[gi]] && !rd_fwd[gi];
  end

  assign bus.rsv_ready = rsv_ready;
  assign bus.busy_vec  = busy;
  assign bus.a0        = a0_val;

  // NOTE: non-blocking updates let a later assignment in this block override
  // an earlier one at the same edge: the highest write port wins, and a
  // reservation set beats a write clear. The register array is reset here
  // (unlike a typical RAM) because reset must clear architectural state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < NREGS; k++) regs[k] <= '0;
      busy <= '0;
    end else begin
      for (int j = 0; j < NWR; j++) begin
        if (wr_commit[j]) begin
          regs[wr_a[j]] <= wr_d[j];
          busy[wr_a[j]] <= 1'b0;
        end
      end
      if (rsv_take) busy[bus.rsv_addr] <= 1'b1;
    end
  end
endmodule

// File: tb/tb_reg_file_sb.sv
// Scoreboard bench for reg_file_sb: directed stimulus queues expectations,
// a negedge monitor drains and compares them. Runs BYPASS=1 and BYPASS=0.
module tb_reg_file_sb;
  localparam int XLEN = 32, NREGS = 32, NRD = 2, NWR = 2, AW = 5;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  reg_file_sb_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) bus ();
  reg_file_sb_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) bus_nb ();

  reg_file_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .BYPASS(1))
    dut (.clk(clk), .rst(rst), .bus(bus));
  reg_file_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .BYPASS(0))
    dut_nb (.clk(clk), .rst(rst), .bus(bus_nb));

  assign bus_nb.rd_addr   = bus.rd_addr;
  assign bus_nb.rsv_valid = bus.rsv_valid;
  assign bus_nb.rsv_addr  = bus.rsv_addr;
  assign bus_nb.wr_en     = bus.wr_en;
  assign bus_nb.wr_addr   = bus.wr_addr;
  assign bus_nb.wr_data   = bus.wr_data;

  typedef enum int {K_RD, K_RD_NB, K_RBUSY, K_BVEC, K_A0, K_RDY} kind_e;
  typedef struct {
    kind_e       kind;
    int          idx;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  function automatic logic [31:0] observe(kind_e k, int idx);
    case (k)
      K_RD:    return bus.rd_data[idx*XLEN +: XLEN];
      K_RD_NB: return bus_nb.rd_data[idx*XLEN +: XLEN];
      K_RBUSY: return 32'(bus.rd_busy[idx]);
      K_BVEC:  return bus.busy_vec;
      K_A0:    return bus.a0;
      K_RDY:   return 32'(bus.rsv_ready);
      default: return '0;
    endcase
  endfunction

  task automatic expect_val(kind_e k, int idx, logic [31:0] v, string name);
    exp_t e;
    e.kind = k;
    e.idx  = idx;
    e.exp  = v;
    e.name = name;
    sb_q.push_back(e);
  endtask

  // Monitor: compares every pending expectation mid-cycle, away from posedge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check(e.name, observe(e.kind, e.idx), e.exp);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.wr_en     = '0;
    bus.rsv_valid = 1'b0;
  endtask

  task automatic set_rd(int p, int a);
    bus.rd_addr[p*AW +: AW] = AW'(a);
  endtask

  task automatic set_wr(int p, int a, logic [31:0] d);
    bus.wr_en[p]                = 1'b1;
    bus.wr_addr[p*AW +: AW]     = AW'(a);
    bus.wr_data[p*XLEN +: XLEN] = d;
  endtask

  task automatic reserve(int a);
    bus.rsv_valid = 1'b1;
    bus.rsv_addr  = AW'(a);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.rd_addr   = '0;
    bus.wr_addr   = '0;
    bus.wr_data   = '0;
    bus.wr_en     = '0;
    bus.rsv_valid = 1'b0;
    bus.rsv_addr  = '0;
    step();

    // Held in reset: everything reads zero, reservations always accepted.
    set_rd(0, 10);
    reserve(4);
    expect_val(K_RD, 0, 32'h0, "rst_rd0");
    expect_val(K_A0, 0, 32'h0, "rst_a0");
    expect_val(K_RDY, 0, 32'h1, "rst_rsv_ready");
    expect_val(K_BVEC, 0, 32'h0, "rst_busy_vec");
    step();
    idle();
    rst = 1'b1;

    // Freshly out of reset: every address reads zero on both ports.
    for (int a = 0; a < NREGS; a++) begin
      set_rd(0, a);
      set_rd(1, NREGS - 1 - a);
      expect_val(K_RD, 0, 32'h0, "init_rd0");
      expect_val(K_RD, 1, 32'h0, "init_rd1");
      step();
    end
    expect_val(K_BVEC, 0, 32'h0, "init_busy_vec");
    expect_val(K_A0, 0, 32'h0, "init_a0");
    step();

    // Same-cycle forwarding versus registered read.
    set_wr(0, 5, 32'hDEADBEEF);
    set_rd(0, 5);
    expect_val(K_RD, 0, 32'hDEADBEEF, "byp_rd0_same");
    expect_val(K_RD_NB, 0, 32'h0, "nobyp_rd0_same");
    expect_val(K_RBUSY, 0, 32'h0, "byp_rd_busy0");
    step();
    idle();
    expect_val(K_RD, 0, 32'hDEADBEEF, "byp_rd0_next");
    expect_val(K_RD_NB, 0, 32'hDEADBEEF, "nobyp_rd0_next");
    step();

    // Register 0 ignores writes, including the forward path.
    set_wr(0, 0, 32'h1234);
    set_rd(0, 0);
    expect_val(K_RD, 0, 32'h0, "r0_rd_same");
    expect_val(K_RD_NB, 0, 32'h0, "r0_rd_nb_same");
    step();
    idle();
    expect_val(K_RD, 0, 32'h0, "r0_rd_after");
    expect_val(K_BVEC, 0, 32'h0, "r0_busy_vec");
    step();

    // Reserve r7, stall a second reservation, then clear it with a write.
    reserve(7);
    set_rd(1, 7);
    expect_val(K_RDY, 0, 32'h1, "r7_ready_free");
    expect_val(K_RBUSY, 1, 32'h0, "r7_rd_busy_free");
    step();
    idle();
    expect_val(K_BVEC, 0, 32'h0000_0080, "r7_busy_vec_set");
    expect_val(K_RDY, 0, 32'h0, "r7_ready_stall");
    expect_val(K_RBUSY, 1, 32'h1, "r7_rd_busy_set");
    step();
    set_wr(1, 7, 32'h55);
    expect_val(K_RD, 1, 32'h55, "r7_rd1_fwd");
    expect_val(K_RBUSY, 1, 32'h0, "r7_rd_busy_fwd");
    expect_val(K_RDY, 0, 32'h0, "r7_ready_clearing");
    expect_val(K_RD_NB, 1, 32'h0, "r7_rd1_nb_old");
    step();
    idle();
    expect_val(K_BVEC, 0, 32'h0, "r7_busy_vec_clr");
    expect_val(K_RDY, 0, 32'h1, "r7_ready_after");
    expect_val(K_RD, 1, 32'h55, "r7_rd1_after");
    step();

    // Two ports and a reservation hit r10 together: port 1 and the set win.
    set_wr(0, 10, 32'h1);
    set_wr(1, 10, 32'h2);
    reserve(10);
    expect_val(K_A0, 0, 32'h2, "r10_a0_fwd");
    expect_val(K_RDY, 0, 32'h1, "r10_ready");
    step();
    idle();
    expect_val(K_A0, 0, 32'h2, "r10_a0_after");
    expect_val(K_BVEC, 0, 32'h0000_0400, "r10_busy_vec");
    expect_val(K_RDY, 0, 32'h0, "r10_ready_stall");
    step();
    set_wr(0, 10, 32'h77);
    expect_val(K_A0, 0, 32'h77, "r10_a0_fwd2");
    step();
    idle();
    expect_val(K_BVEC, 0, 32'h0, "r10_busy_clr");
    expect_val(K_A0, 0, 32'h77, "r10_a0_hold");
    step();

    // r3: reserve, write, reserve again, then reset before the second write.
    reserve(3);
    set_rd(0, 3);
    step();
    idle();
    set_wr(0, 3, 32'hAA);
    expect_val(K_BVEC, 0, 32'h0000_0008, "r3_busy_vec_set");
    expect_val(K_RD, 0, 32'hAA, "r3_rd0_fwd");
    step();
    idle();
    expect_val(K_RD, 0, 32'hAA, "r3_rd0_after");
    expect_val(K_BVEC, 0, 32'h0, "r3_busy_vec_clr");
    step();
    reserve(3);
    step();
    idle();
    expect_val(K_BVEC, 0, 32'h0000_0008, "r3_busy_vec_reserved");
    step();
    rst = 1'b0;
    set_wr(0, 3, 32'hBB);
    reserve(3);
    expect_val(K_RD, 0, 32'h0, "rstpulse_rd0");
    expect_val(K_BVEC, 0, 32'h0, "rstpulse_busy_vec");
    expect_val(K_A0, 0, 32'h0, "rstpulse_a0");
    expect_val(K_RDY, 0, 32'h1, "rstpulse_ready");
    expect_val(K_RBUSY, 0, 32'h0, "rstpulse_rd_busy0");
    step();
    rst = 1'b1;
    idle();
    expect_val(K_RD, 0, 32'h0, "rstpulse_wr_discarded");
    expect_val(K_BVEC, 0, 32'h0, "rstpulse_rsv_discarded");
    step();
    set_wr(0, 3, 32'hCC);
    reserve(3);
    expect_val(K_RDY, 0, 32'h1, "post_rst_ready");
    step();
    idle();
    expect_val(K_RD, 0, 32'hCC, "post_rst_rd0");
    expect_val(K_BVEC, 0, 32'h0000_0008, "post_rst_busy_vec");
    step();

    @(negedge clk);
    #1;
    check("queue_drained", 32'(sb_q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
